cache_seq_ctrl: RTL

Sequencing FSM for the direct-mapped cache datapath. It steps the address reader, latches each address, and runs a cache lookup. On a hit it forwards the cache word to the output register. On a miss it fetches the block from data memory, fills the cache and forwards the memory word. It sits beside the datapath on the system clock, drives all of its enables and strobes, and also keeps hit/miss statistics and a per-wait watchdog.

---
 rtl/cache_seq_pkg.sv | 28 ++
 rtl/cache_seq_ctrl_wait_timer.sv | 27 ++
 rtl/cache_seq_ctrl.sv | 139 +++++++++++++
 3 files changed

// File: rtl/cache_seq_pkg.sv
// Shared types and defaults for the direct-mapped cache sequencer.
package cache_seq_pkg;

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    FETCH  = 4'd1,
    CHECK  = 4'd2,
    LATCH  = 4'd3,
    LOOKUP = 4'd4,
    WAIT_C = 4'd5,
    OUT_C  = 4'd6,
    MEM_RD = 4'd7,
    WAIT_M = 4'd8,
    FILL   = 4'd9,
    WAIT_F = 4'd10,
    OUT_M  = 4'd11,
    DONE   = 4'd12,
    ERR    = 4'd13
  } state_t;

  localparam int CNT_W_DEF   = 16;
  localparam int TIMEOUT_DEF = 255;

  function automatic logic is_wait(input state_t s);
    return (s == WAIT_C) || (s == WAIT_M) || (s == WAIT_F);
  endfunction

endpackage

// File: rtl/cache_seq_ctrl_wait_timer.sv
// Watchdog shared by all wait states; expired flags the last allowed wait cycle.
module wait_timer #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic en,
  output logic expired
);
  localparam int W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  logic [W-1:0] cnt;

  // Counts the cycles already spent waiting; TIMEOUT-1 means this is the last one.
  assign expired = en && (cnt >= W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (!rst_n)
      cnt <= '0;
    else if (clear)
      cnt <= '0;
    else if (en && !expired)
      cnt <= cnt + W'(1);
  end

endmodule

// File: rtl/cache_seq_ctrl.sv
// Sequencer for the direct-mapped cache datapath: reader, lookup, miss fill, output.
module cache_seq_ctrl
  import cache_seq_pkg::*;
#(
  parameter int CNT_W   = CNT_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             dataFinish,
  input  logic             readyCache,
  input  logic             find,
  input  logic             need,
  input  logic             readyMem,
  input  logic             writed,
  output logic             readerEn,
  output logic             adrEn,
  output logic             startCache,
  output logic             startMem,
  output logic             We,
  output logic             forc,
  output logic             MemSel,
  output logic             outputEn,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] hit_count,
  output logic [CNT_W-1:0] miss_count
);

  state_t state, state_next;
  logic   expired;
  logic   hit_inc, miss_inc, cnt_clr;
  logic   unused_need;

  // A miss always fills, so the fill-request hint carries no information here.
  assign unused_need = need;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  wait_timer #(.TIMEOUT(TIMEOUT)) u_wait_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (is_wait(state_next) && (state_next != state)),
    .en     (is_wait(state)),
    .expired(expired)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    hit_inc    = 1'b0;
    miss_inc   = 1'b0;
    cnt_clr    = 1'b0;
    case (state)
      IDLE, DONE: if (start) begin
        state_next = FETCH;
        cnt_clr    = 1'b1;
      end
      FETCH:  state_next = CHECK;
      CHECK:  state_next = dataFinish ? DONE : LATCH;
      LATCH:  state_next = LOOKUP;
      LOOKUP: state_next = WAIT_C;
      // A ready arriving on the expiry cycle still completes the wait.
      WAIT_C: begin
        if (readyCache) begin
          state_next = find ? OUT_C : MEM_RD;
          hit_inc    = find;
          miss_inc   = !find;
        end else if (expired) begin
          state_next = ERR;
        end
      end
      OUT_C:  state_next = FETCH;
      MEM_RD: state_next = WAIT_M;
      WAIT_M: begin
        if (readyMem)     state_next = FILL;
        else if (expired) state_next = ERR;
      end
      FILL:   state_next = WAIT_F;
      WAIT_F: begin
        if (writed)       state_next = OUT_M;
        else if (expired) state_next = ERR;
      end
      OUT_M:  state_next = FETCH;
      ERR:    state_next = ERR;
      default: state_next = IDLE;
    endcase
  end

  // Registered Moore outputs decoded from the next state, so each lines up with its state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      readerEn   <= 1'b0;
      adrEn      <= 1'b0;
      startCache <= 1'b0;
      startMem   <= 1'b0;
      We         <= 1'b0;
      forc       <= 1'b0;
      MemSel     <= 1'b0;
      outputEn   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      readerEn   <= (state_next == FETCH);
      adrEn      <= (state_next == LATCH);
      startCache <= (state_next == LOOKUP) || (state_next == FILL);
      startMem   <= (state_next == MEM_RD);
      We         <= (state_next == FILL) || (state_next == WAIT_F);
      forc       <= (state_next == MEM_RD) || (state_next == WAIT_M) ||
                    (state_next == FILL)   || (state_next == WAIT_F);
      MemSel     <= (state_next == MEM_RD) || (state_next == WAIT_M) ||
                    (state_next == FILL)   || (state_next == WAIT_F) ||
                    (state_next == OUT_M);
      outputEn   <= (state_next == OUT_C) || (state_next == OUT_M);
      busy       <= !((state_next == IDLE) || (state_next == DONE) || (state_next == ERR));
      done       <= (state_next == DONE);
      err        <= (state_next == ERR);
      if (cnt_clr) begin
        hit_count  <= '0;
        miss_count <= '0;
      end else begin
        if (hit_inc)  hit_count  <= sat_inc(hit_count);
        if (miss_inc) miss_count <= sat_inc(miss_count);
      end
    end
  end

endmodule
